// File: rtl/muldiv_ctrl_if.sv
// Signal bundle between the execute stage, the external multiplier/divider
// and the HI/LO sequencing controller.
interface muldiv_ctrl_if;
   logic        start_i;
   logic [3:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        flush_i;
   logic        hi_we_i;
   logic        lo_we_i;
   logic [31:0] mt_data_i;
   logic [31:0] mul_a_o;
   logic [31:0] mul_b_o;
   logic        mul_signed_o;
   logic [63:0] mul_p_i;
   logic        div_start_o;
   logic        div_signed_o;
   logic [31:0] div_a_o;
   logic [31:0] div_b_o;
   logic        div_abort_o;
   logic        div_done_i;
   logic [31:0] div_q_i;
   logic [31:0] div_r_i;
   logic        stall_o;
   logic        done_o;
   logic [31:0] mul_gpr_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   modport slave (
      input  start_i, op_i, a_i, b_i, flush_i, hi_we_i, lo_we_i, mt_data_i,
             mul_p_i, div_done_i, div_q_i, div_r_i,
      output mul_a_o, mul_b_o, mul_signed_o, div_start_o, div_signed_o,
             div_a_o, div_b_o, div_abort_o, stall_o, done_o, mul_gpr_o, hi_o, lo_o
   );

   modport master (
      output start_i, op_i, a_i, b_i, flush_i, hi_we_i, lo_we_i, mt_data_i,
             mul_p_i, div_done_i, div_q_i, div_r_i,
      input  mul_a_o, mul_b_o, mul_signed_o, div_start_o, div_signed_o,
             div_a_o, div_b_o, div_abort_o, stall_o, done_o, mul_gpr_o, hi_o, lo_o
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: drives a fixed-latency multiplier and a
// handshaked divider, owns HI/LO (incl. MADD/MSUB accumulation), stalls the pipe.
module muldiv_ctrl #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic         clk,
   input  logic         resetn,
   muldiv_ctrl_if.slave bus
);
   localparam int unsigned W     = 32;
   localparam int unsigned CNT_W = 3;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MUL   = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;

   typedef enum logic [1:0] {IDLE, MUL_WAIT, ACC, DIV_WAIT} state_t;

   state_t           state;
   logic [3:0]       op_r;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     a_r, b_r, hi_r, lo_r, gpr_r;
   logic [2*W-1:0]   prod_r;
   logic             mul_signed_r, div_signed_r, div_start_r, div_abort_r;
   logic             valid_op, is_div, accept, is_acc, mul_last, commit;

   assign valid_op = bus.op_i <= OP_MSUBU;
   assign is_div   = (bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU);
   assign accept   = (state == IDLE) && bus.start_i && valid_op && !bus.flush_i;
   assign is_acc   = op_r >= OP_MADD;
   assign mul_last = (state == MUL_WAIT) && (cnt == CNT_W'(1));

   // A flush landing in the completing cycle cancels the commit
   always_comb begin
      commit = 1'b0;
      unique case (state)
         MUL_WAIT: commit = mul_last && !is_acc;
         ACC:      commit = 1'b1;
         DIV_WAIT: commit = bus.div_done_i;
         default:  commit = 1'b0;
      endcase
      if (bus.flush_i) commit = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         op_r         <= '0;
         cnt          <= '0;
         a_r          <= '0;
         b_r          <= '0;
         hi_r         <= '0;
         lo_r         <= '0;
         gpr_r        <= '0;
         prod_r       <= '0;
         mul_signed_r <= 1'b0;
         div_signed_r <= 1'b0;
         div_start_r  <= 1'b0;
         div_abort_r  <= 1'b0;
      end else begin
         div_start_r <= 1'b0;
         div_abort_r <= 1'b0;
         unique case (state)
            IDLE: begin
               // MT writes land before an accepted op reads HI/LO
               if (bus.hi_we_i) hi_r <= bus.mt_data_i;
               if (bus.lo_we_i) lo_r <= bus.mt_data_i;
               if (accept) begin
                  op_r <= bus.op_i;
                  a_r  <= bus.a_i;
                  b_r  <= bus.b_i;
                  if (is_div) begin
                     state        <= DIV_WAIT;
                     div_start_r  <= 1'b1;
                     div_signed_r <= (bus.op_i == OP_DIV);
                  end else begin
                     state        <= MUL_WAIT;
                     cnt          <= CNT_W'(MUL_LAT);
                     mul_signed_r <= (bus.op_i == OP_MULT) || (bus.op_i == OP_MUL) ||
                                     (bus.op_i == OP_MADD) || (bus.op_i == OP_MSUB);
                  end
               end
            end
            MUL_WAIT: begin
               if (bus.flush_i) begin
                  state <= IDLE;
               end else if (mul_last) begin
                  if (is_acc) begin
                     prod_r <= bus.mul_p_i;
                     state  <= ACC;
                  end else begin
                     if (op_r == OP_MUL) gpr_r <= bus.mul_p_i[W-1:0];
                     else {hi_r, lo_r} <= bus.mul_p_i;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ACC: begin
               if (!bus.flush_i)
                  {hi_r, lo_r} <= (op_r >= OP_MSUB) ? ({hi_r, lo_r} - prod_r)
                                                    : ({hi_r, lo_r} + prod_r);
               state <= IDLE;
            end
            DIV_WAIT: begin
               if (bus.flush_i) begin
                  state       <= IDLE;
                  div_abort_r <= 1'b1;
               end else if (bus.div_done_i) begin
                  lo_r  <= bus.div_q_i;
                  hi_r  <= bus.div_r_i;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mul_a_o      = a_r;
   assign bus.mul_b_o      = b_r;
   assign bus.div_a_o      = a_r;
   assign bus.div_b_o      = b_r;
   assign bus.mul_signed_o = mul_signed_r;
   assign bus.div_signed_o = div_signed_r;
   assign bus.div_start_o  = div_start_r;
   assign bus.div_abort_o  = div_abort_r;
   assign bus.hi_o         = hi_r;
   assign bus.lo_o         = lo_r;
   assign bus.mul_gpr_o    = gpr_r;
   assign bus.done_o       = commit;
   assign bus.stall_o      = accept || ((state != IDLE) && !commit);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: reference HI/LO model, multiplier and
// divider stubs, directed corner cases followed by randomized operations.
module tb_muldiv_ctrl;
   localparam int unsigned MUL_LAT = 2;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MUL   = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MADDU = 4'd6;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;

   typedef struct {
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] gpr;
   } exp_t;

   logic clk;
   logic resetn;
   muldiv_ctrl_if bus ();

   muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          dstart_cyc = -1;
   int          dabort_cyc = -1;
   int          div_lat = 1;
   bit          skip_stall = 1'b0;
   bit          pend_chk = 1'b0;
   exp_t        pend;
   exp_t        sb[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] m_gpr = '0;
   logic [63:0] mprod;
   logic [63:0] mdly [MUL_LAT];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
      return 64'(longint'(a) * longint'(b));
   endfunction

   function automatic void div_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                   output logic [31:0] q, output logic [31:0] r);
      longint n, d;
      if (b == 32'd0) begin
         q = '1;
         r = a;
      end else begin
         n = sgn ? longint'($signed(a)) : longint'(a);
         d = sgn ? longint'($signed(b)) : longint'(b);
         q = 32'(n / d);
         r = 32'(n % d);
      end
   endfunction

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Multiplier stub: product of the registered operands, MUL_LAT cycles after they appear
   always_comb mprod = mul64(bus.mul_a_o, bus.mul_b_o, bus.mul_signed_o);
   always @(posedge clk) begin
      mdly[0] <= mprod;
      for (int i = 1; i < int'(MUL_LAT); i++) mdly[i] <= mdly[i-1];
   end
   assign bus.mul_p_i = mdly[MUL_LAT-2];

   // Divider stub: answers div_lat cycles after the start pulse, garbage otherwise
   initial begin
      logic [31:0] da, db, q, r;
      bit          dsg;
      int          n;
      bus.div_done_i = 1'b0;
      bus.div_q_i    = '0;
      bus.div_r_i    = '0;
      forever begin
         @(negedge clk);
         if (bus.div_start_o === 1'b1) begin
            da  = bus.div_a_o;
            db  = bus.div_b_o;
            dsg = bus.div_signed_o;
            n   = div_lat;
            repeat (n) @(posedge clk);
            #1;
            div_ref(da, db, dsg, q, r);
            bus.div_q_i    = q;
            bus.div_r_i    = r;
            bus.div_done_i = 1'b1;
            tick();
            bus.div_done_i = 1'b0;
            bus.div_q_i    = $urandom;
            bus.div_r_i    = $urandom;
         end
      end
   end

   // Monitor: pulses, stall, commit timing and post-commit register values
   always @(negedge clk) begin
      exp_t it;
      if (pend_chk) begin
         check_eq("hi_o", 64'(bus.hi_o), 64'(pend.hi));
         check_eq("lo_o", 64'(bus.lo_o), 64'(pend.lo));
         check_eq("mul_gpr_o", 64'(bus.mul_gpr_o), 64'(pend.gpr));
         pend_chk = 1'b0;
      end
      check_eq("div_start_o", 64'(bus.div_start_o), 64'(cyc == dstart_cyc));
      check_eq("div_abort_o", 64'(bus.div_abort_o), 64'(cyc == dabort_cyc));
      if (!skip_stall)
         check_eq("stall_o", 64'(bus.stall_o), 64'((sb.size() != 0) && !bus.done_o));
      if (sb.size() == 0) begin
         check_eq("done_o_unexpected", 64'(bus.done_o), 64'd0);
      end else if (bus.done_o === 1'b1) begin
         it = sb.pop_front();
         check_eq("commit_cycle", 64'(cyc), 64'(it.cyc));
         pend     = it;
         pend_chk = 1'b1;
      end
   end

   task automatic chk_reset();
      check_eq("rst_hi_lo", {bus.hi_o, bus.lo_o}, 64'd0);
      check_eq("rst_gpr", 64'(bus.mul_gpr_o), 64'd0);
      check_eq("rst_mul_ops", {bus.mul_a_o, bus.mul_b_o}, 64'd0);
      check_eq("rst_div_ops", {bus.div_a_o, bus.div_b_o}, 64'd0);
      check_eq("rst_flags", 64'({bus.stall_o, bus.done_o, bus.div_start_o, bus.div_abort_o,
                                 bus.mul_signed_o, bus.div_signed_o}), 64'd0);
   endtask

   task automatic mt_cycle(input logic hwe, input logic lwe, input logic [31:0] d);
      bus.hi_we_i   = hwe;
      bus.lo_we_i   = lwe;
      bus.mt_data_i = d;
      if (hwe) m_hi = d;
      if (lwe) m_lo = d;
      tick();
      bus.hi_we_i = 1'b0;
      bus.lo_we_i = 1'b0;
   endtask

   // Present one request for a cycle; the model result is queued only when push is set
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic hwe, input logic lwe, input logic [31:0] mt,
                        input int dlat, input bit push);
      exp_t        e;
      logic [63:0] p;
      logic [31:0] q, r;
      bit          sgn, dv;
      div_lat = dlat;
      bus.start_i   = 1'b1;
      bus.op_i      = op;
      bus.a_i       = a;
      bus.b_i       = b;
      bus.hi_we_i   = hwe;
      bus.lo_we_i   = lwe;
      bus.mt_data_i = mt;
      if (hwe) m_hi = mt;
      if (lwe) m_lo = mt;
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.gpr = m_gpr;
      e.cyc = cyc + int'(MUL_LAT);
      sgn = (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
      dv  = (op == OP_DIV) || (op == OP_DIVU);
      p   = mul64(a, b, sgn);
      case (op)
         OP_MULT, OP_MULTU: {e.hi, e.lo} = p;
         OP_MUL:            e.gpr = p[31:0];
         OP_MADD, OP_MADDU: begin {e.hi, e.lo} = {m_hi, m_lo} + p; e.cyc = e.cyc + 1; end
         OP_MSUB, OP_MSUBU: begin {e.hi, e.lo} = {m_hi, m_lo} - p; e.cyc = e.cyc + 1; end
         OP_DIV, OP_DIVU: begin
            div_ref(a, b, sgn, q, r);
            e.lo = q;
            e.hi = r;
            e.cyc = cyc + 1 + dlat;
            dstart_cyc = cyc + 1;
         end
         default: ;
      endcase
      if (op <= OP_MSUBU && push) begin
         sb.push_back(e);
         m_hi  = e.hi;
         m_lo  = e.lo;
         m_gpr = e.gpr;
      end
      tick();
      bus.start_i = 1'b0;
      bus.hi_we_i = 1'b0;
      bus.lo_we_i = 1'b0;
      if (op <= OP_MSUBU) begin
         check_eq("operands", {bus.mul_a_o, bus.mul_b_o}, {a, b});
         check_eq("div_operands", {bus.div_a_o, bus.div_b_o}, {a, b});
         if (dv) check_eq("div_signed_o", 64'(bus.div_signed_o), 64'(sgn));
         else    check_eq("mul_signed_o", 64'(bus.mul_signed_o), 64'(sgn));
      end
   endtask

   // Wait for the scoreboard to drain; noise pokes MT strobes that a busy unit must ignore
   task automatic wait_done(input bit noise);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         if (noise) begin
            bus.hi_we_i   = ($urandom_range(0, 3) == 0);
            bus.lo_we_i   = ($urandom_range(0, 3) == 0);
            bus.mt_data_i = $urandom;
         end
         tick();
         n++;
      end
      bus.hi_we_i = 1'b0;
      bus.lo_we_i = 1'b0;
      check_eq("completion_timeout", 64'(n < 100), 64'd1);
      if (n >= 100) sb.delete();
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'hFFFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] sa;
      resetn        = 1'b0;
      bus.start_i   = 1'b0;
      bus.op_i      = '0;
      bus.a_i       = '0;
      bus.b_i       = '0;
      bus.flush_i   = 1'b0;
      bus.hi_we_i   = 1'b0;
      bus.lo_we_i   = 1'b0;
      bus.mt_data_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset();
      tick();
      resetn = 1'b1;
      tick();

      issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, '0, 1, 1'b1);
      wait_done(1'b0);
      check_eq("mult_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, '0, 1, 1'b1);
      wait_done(1'b0);
      check_eq("multu_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0001_FFFF_FFFE);

      mt_cycle(1'b1, 1'b0, 32'd0);
      issue(OP_MADD, 32'd1, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1, 1'b1);
      wait_done(1'b0);
      check_eq("madd_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0001_0000_0000);

      mt_cycle(1'b1, 1'b1, 32'd0);
      issue(OP_MSUB, 32'd1, 32'd1, 1'b0, 1'b0, '0, 1, 1'b1);
      wait_done(1'b0);
      check_eq("msub_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      issue(OP_MUL, 32'd3, 32'd5, 1'b0, 1'b0, '0, 1, 1'b1);
      wait_done(1'b0);
      check_eq("mul_gpr", 64'(bus.mul_gpr_o), 64'd15);
      check_eq("mul_hilo_kept", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);

      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 10, 1'b1);
      wait_done(1'b0);
      check_eq("div_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

      // Flush while waiting on the divider; its late answer must be dropped
      skip_stall = 1'b1;
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, '0, 10, 1'b0);
      repeat (3) tick();
      bus.flush_i = 1'b1;
      dabort_cyc  = cyc + 1;
      tick();
      bus.flush_i = 1'b0;
      repeat (14) tick();
      check_eq("flush_div_hilo", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});

      // Flush in the MULT commit cycle
      issue(OP_MULT, 32'd7, 32'd9, 1'b0, 1'b0, '0, 1, 1'b0);
      repeat (MUL_LAT - 1) tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      tick();
      check_eq("flush_mult_hilo", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});

      // Asynchronous reset in the middle of MUL_WAIT
      issue(OP_MULTU, 32'd11, 32'd13, 1'b0, 1'b0, '0, 1, 1'b0);
      resetn = 1'b0;
      @(negedge clk);
      chk_reset();
      m_hi  = '0;
      m_lo  = '0;
      m_gpr = '0;
      tick();
      resetn = 1'b1;
      tick();
      skip_stall = 1'b0;
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd4, 1'b0, 1'b0, '0, 1, 1'b1);
      wait_done(1'b0);
      check_eq("post_reset_mult", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFF4);

      // Undefined opcode must neither stall nor latch anything
      sa = bus.mul_a_o;
      issue(4'd12, 32'h1234_5678, 32'd2, 1'b0, 1'b0, '0, 1, 1'b0);
      check_eq("invalid_op_no_latch", 64'(bus.mul_a_o), 64'(sa));
      issue(OP_MUL, 32'd6, 32'd7, 1'b0, 1'b0, '0, 1, 1'b1);
      wait_done(1'b0);
      check_eq("after_invalid_mul", 64'(bus.mul_gpr_o), 64'd42);

      for (int i = 0; i < 80; i++) begin
         issue(4'($urandom_range(0, 8)), pick(), pick(),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), $urandom,
               int'($urandom_range(1, 6)), 1'b1);
         wait_done(1'b1);
      end
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the multi-cycle multiply/divide resource in the execute stage. It accepts one HI/LO-class operation per request flagged by the decoder's mul/div enable (MULT/MULTU/DIV/DIVU/MUL/MADD/MADDU/MSUB/MSUBU). It drives an external fixed-latency multiplier and an external handshaked divider, owns the architectural HI/LO registers including MADD/MSUB accumulation, and stalls the pipeline until the result is committed.

## Interface
- MUL_LAT, 2: multiplier latency in cycles, 1..7.
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- start_i  in  1  operation request in E stage.
- op_i  in  4  operation code:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MUL, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU.
  - Codes 9..15 are ignored: treated as no request.
- a_i, b_i  in  32  rs and rt operands.
- flush_i  in  1  exception/eret flush.
- hi_we_i, lo_we_i  in  1  MTHI/MTLO write strobes.
- mt_data_i  in  32  MTHI/MTLO data.
- mul_a_o, mul_b_o  out  32  multiplier operands.
- mul_signed_o  out  1  signed multiply.
- mul_p_i  in  64  product, valid MUL_LAT cycles after operands are registered.
- div_start_o  out  1  one-cycle divider start pulse.
- div_signed_o  out  1  signed divide.
- div_a_o, div_b_o  out  32  dividend and divisor.
- div_abort_o  out  1  one-cycle cancel pulse.
- div_done_i  in  1  divider result valid (one cycle).
- div_q_i, div_r_i  in  32  quotient and remainder.
- stall_o  out  1  pipeline stall.
- done_o  out  1  commit pulse.
- mul_gpr_o  out  32  low word of the MUL product, registered.
- hi_o, lo_o  out  32  architectural HI and LO.

## Operation
- States: IDLE, MUL_WAIT, ACC, DIV_WAIT.
- Reset: IDLE, hi_o=lo_o=0, mul_gpr_o=0, operand registers 0, div_start_o=div_abort_o=done_o=0, stall_o=0.
- IDLE, start_i=1, valid op, flush_i=0: latch op, a_i and b_i.
  - Mult-class ops: load counter with MUL_LAT and go to MUL_WAIT. mul_signed_o=1 for MULT/MUL/MADD/MSUB.
  - DIV/DIVU: pulse div_start_o next cycle and go to DIV_WAIT. div_signed_o=1 for DIV.
- MUL_WAIT: decrement the counter each cycle. At zero:
  - MULT/MULTU: {HI,LO}=mul_p_i.
  - MUL: mul_gpr_o=mul_p_i[31:0]; HI/LO unchanged.
  - Commit and return to IDLE.
  - MADD/MSUB variants: latch mul_p_i and go to ACC.
- ACC: {HI,LO} = {HI,LO} ± latched product, 64-bit modulo 2^64, using the current HI/LO. Commit and return to IDLE.
- DIV_WAIT: hold until div_done_i. Then LO=div_q_i, HI=div_r_i, commit, return to IDLE. A zero divisor is not special-cased; the commit takes whatever the divider returns.
- Commit cycle: done_o=1 for one cycle, state becomes IDLE.
- stall_o is combinational: (IDLE & start_i & valid op & ~flush_i) | (state≠IDLE & ~commit).
- flush_i in any non-IDLE state, including the commit cycle:
  - Discard the operation; HI/LO and mul_gpr_o are unchanged; done_o=0.
  - Next state is IDLE.
  - div_abort_o pulses the next cycle if the state was DIV_WAIT.
- hi_we_i/lo_we_i are honoured only in IDLE; the pipeline is stalled otherwise. An MT write and a start in the same cycle: the MT write lands first. A subsequent MADD accumulates onto the written value.
- div_done_i outside DIV_WAIT is ignored.

## Timing
- Request accepted in cycle T.
- MULT/MULTU/MUL: commit at T+MUL_LAT; HI/LO and mul_gpr_o are visible at T+MUL_LAT+1.
- MADD family: commit at T+MUL_LAT+1.
- DIV: div_start_o high at T+1. Commit in the cycle div_done_i is high (earliest T+2). Divider latency is unbounded.
- stall_o is high from T through the cycle before commit and low in the commit cycle, so the instruction advances exactly once.
- Back-to-back: a new start_i is accepted in the cycle after commit.
- Asynchronous reset mid-operation returns to IDLE immediately with all reset values; the divider is not sent an abort.

## Test plan
- MULT a=0xFFFFFFFF b=2, MUL_LAT=2 -> stall_o high 2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE at T+3. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- MTLO 0xFFFFFFFF in the same cycle as MADD a=1 b=1 (HI=0) -> HI=0x00000001, LO=0x00000000 at T+4; done_o a single pulse.
- MSUB a=1 b=1 from HI=LO=0 -> HI=LO=0xFFFFFFFF. MUL a=3 b=5 -> mul_gpr_o=15, HI/LO unchanged.
- DIV a=0xFFFFFFF9 (-7) b=2, divider stub answering after 10 cycles -> div_start_o pulse at T+1, div_signed_o=1, stall_o held until done; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- flush_i during DIV_WAIT -> div_abort_o pulse, HI/LO unchanged, no done_o; a late div_done_i is ignored. flush_i in the MULT commit cycle -> HI/LO unchanged.
- resetn low mid-MUL_WAIT -> all outputs at reset values; the next MULT completes normally. Invalid op_i=12 with start_i -> no stall, no state change.
